nonce_dispatcher: RTL and testbench
===================================

NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1024, max cycles in WAIT before a core timeout is declared.
REQ-002 SHALL have port: clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: work_valid in 1, work_ready out 1; job-offer handshake.
REQ-005 SHALL have ports: work_block in 608 and work_target in 256; header without nonce, and target.
REQ-006 SHALL have ports: nonce_start in 32 and nonce_end in 32; inclusive search range.
REQ-007 SHALL have port: abort  in  1  terminate the current job.
REQ-008 SHALL have ports to the hash core: hash_enable out 1, block out 608, nonce out 32, target out 256, finished in 1, correct in 1, hashed in 256.
REQ-009 SHALL have result ports: result_valid out 1, result_ack in 1, result_code out 2, found_nonce out 32, found_hash out 256, attempts out 33.

Function
REQ-010 SHALL implement the FSM states IDLE, LAUNCH, WAIT, CHECK and DONE.
REQ-011 work_ready SHALL equal (state==IDLE); on work_valid&&work_ready, block/target/nonce SHALL latch work_block/work_target/nonce_start, the end register SHALL latch nonce_end, attempts SHALL clear, and the FSM SHALL go to LAUNCH.
REQ-012 block, target and the end register SHALL hold constant from accept until the next accept.
REQ-013 In LAUNCH, hash_enable SHALL be 1 for exactly that one cycle, the WAIT timer SHALL clear, and the next state SHALL be WAIT; hash_enable SHALL be 0 in every other state.
REQ-014 In WAIT, finished==1 SHALL latch correct and hashed and go to CHECK; finished SHALL take priority over abort and timeout in the same cycle.
REQ-015 In WAIT without finished, abort SHALL go to DONE with code 00 (ABORTED); otherwise the timer SHALL increment, and when the timer equals TIMEOUT_CYCLES-1 the FSM SHALL go to DONE with code 11 (TIMEOUT).
REQ-016 In CHECK, attempts SHALL increment by 1 (33-bit, so a full 2^32 sweep is representable).
REQ-017 In CHECK, if the latched correct is 1, found_nonce SHALL get nonce, found_hash SHALL get the latched hash, code SHALL be 01 (FOUND), and the next state SHALL be DONE.
REQ-018 In CHECK, otherwise if nonce==end, code SHALL be 10 (EXHAUSTED) and the next state SHALL be DONE; otherwise, if abort, code SHALL be 00 and the next state SHALL be DONE; else nonce SHALL increment modulo 2^32 (FFFFFFFF wraps to 00000000) and the next state SHALL be LAUNCH.
REQ-019 nonce_start==nonce_end SHALL yield exactly one attempt; nonce_end < nonce_start SHALL search through the wrap.
REQ-020 abort in LAUNCH SHALL be ignored, and the launch SHALL complete.
REQ-021 abort in IDLE or DONE SHALL have no effect.
REQ-022 In DONE, result_valid SHALL be 1, and result_code, found_nonce, found_hash and attempts SHALL hold stable; result_ack SHALL go to IDLE.
REQ-023 found_nonce and found_hash SHALL remain 0 unless code is FOUND.

Reset
REQ-024 rst sampled high SHALL, on that edge and from any state: set the state to IDLE; set work_ready=1; set hash_enable=0 and result_valid=0; and set nonce, block, target, result_code, found_nonce, found_hash, attempts and the timer to 0.
REQ-025 rst mid-job SHALL discard the job without emitting a result.

Structure
REQ-026 The shared package miner_pkg SHALL hold BLOCK_W=608, NONCE_W=32, HASH_W=256, the state enum, and the result_code enum (ABORTED=00, FOUND=01, EXHAUSTED=10, TIMEOUT=11).
REQ-027 The WAIT timer SHALL be one sub-module, miner_watchdog (clear, enable, expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-028 The bench SHALL drive a behavioural core model (finished 4 cycles after hash_enable) with the 608-bit test header.
REQ-029 Found: start 9546A140, end 9546A14F, model correct only at 9546A142 -> FOUND, found_nonce=9546A142, attempts=3, exactly 3 hash_enable pulses.
REQ-030 Single: start=end=00000005, never correct -> EXHAUSTED, attempts=1, nonce=00000005.
REQ-031 Wrap: start FFFFFFFE, end 00000001, never correct -> nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001 in order, EXHAUSTED, attempts=4.
REQ-032 Timeout: TIMEOUT_CYCLES=16, finished never asserted -> TIMEOUT, DONE entered 16 cycles after WAIT entry, attempts=0.
REQ-033 Priority: abort on the same cycle as finished&&correct at nonce 9546A142 -> FOUND; abort alone in WAIT -> ABORTED.
REQ-034 Reset: rst during WAIT of attempt 2 -> next cycle IDLE, all outputs at reset values, no result_valid pulse.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared widths, FSM state encoding and result codes for the nonce search
// dispatcher and its watchdog.
package miner_pkg;

  localparam int BLOCK_W   = 608;
  localparam int NONCE_W   = 32;
  localparam int HASH_W    = 256;
  localparam int ATTEMPT_W = NONCE_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RC_ABORTED   = 2'b00,
    RC_FOUND     = 2'b01,
    RC_EXHAUSTED = 2'b10,
    RC_TIMEOUT   = 2'b11
  } result_code_e;

endpackage

// File: rtl/miner_watchdog.sv
// Cycle counter that bounds how long the dispatcher waits for one hash result.
// expired is combinational, so the caller can leave WAIT on the same edge.
module miner_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  // Counter stops at LAST; the dispatcher leaves WAIT on that cycle anyway.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Sweeps an inclusive nonce range through an external hash core, one nonce at a
// time, and reports FOUND / EXHAUSTED / ABORTED / TIMEOUT with the attempt count.
module nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  // Handshakes: a transfer happens on any rising edge where valid && ready are
  // both high; valid never waits on ready, and ready is a pure function of state.
  input  logic                 work_valid,
  output logic                 work_ready,
  input  logic [BLOCK_W-1:0]   work_block,
  input  logic [HASH_W-1:0]    work_target,
  input  logic [NONCE_W-1:0]   nonce_start,
  input  logic [NONCE_W-1:0]   nonce_end,
  input  logic                 abort,
  output logic                 hash_enable,
  output logic [BLOCK_W-1:0]   block,
  output logic [NONCE_W-1:0]   nonce,
  output logic [HASH_W-1:0]    target,
  input  logic                 finished,
  input  logic                 correct,
  input  logic [HASH_W-1:0]    hashed,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic [1:0]           result_code,
  output logic [NONCE_W-1:0]   found_nonce,
  output logic [HASH_W-1:0]    found_hash,
  output logic [ATTEMPT_W-1:0] attempts,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
  localparam logic [2:0] S_WAIT   = ST_WAIT;
  localparam logic [2:0] S_CHECK  = ST_CHECK;
  localparam logic [2:0] S_DONE   = ST_DONE;

  logic [2:0]         state;
  logic [NONCE_W-1:0] end_nonce;
  logic               corr_q;
  logic [HASH_W-1:0]  hash_q;
  logic               wd_clear;
  logic               wd_enable;
  logic               wd_expired;

  assign work_ready   = (state == S_IDLE);
  assign hash_enable  = (state == S_LAUNCH);
  assign result_valid = (state == S_DONE);
  assign dbg_state    = state;

  assign wd_clear  = (state == S_LAUNCH);
  assign wd_enable = (state == S_WAIT);

  miner_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      block       <= '0;
      target      <= '0;
      nonce       <= '0;
      end_nonce   <= '0;
      corr_q      <= 1'b0;
      hash_q      <= '0;
      result_code <= '0;
      found_nonce <= '0;
      found_hash  <= '0;
      attempts    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (work_valid) begin
            block       <= work_block;
            target      <= work_target;
            nonce       <= nonce_start;
            end_nonce   <= nonce_end;
            attempts    <= '0;
            result_code <= '0;
            found_nonce <= '0;
            found_hash  <= '0;
            state       <= S_LAUNCH;
          end
        end

        // abort is deliberately not looked at here: a launch always completes.
        S_LAUNCH: begin
          state <= S_WAIT;
        end

        // A finishing core wins over abort and the watchdog in the same cycle.
        S_WAIT: begin
          if (finished) begin
            corr_q <= correct;
            hash_q <= hashed;
            state  <= S_CHECK;
          end else if (abort) begin
            result_code <= RC_ABORTED;
            state       <= S_DONE;
          end else if (wd_expired) begin
            result_code <= RC_TIMEOUT;
            state       <= S_DONE;
          end
        end

        S_CHECK: begin
          attempts <= attempts + ATTEMPT_W'(1);
          if (corr_q) begin
            found_nonce <= nonce;
            found_hash  <= hash_q;
            result_code <= RC_FOUND;
            state       <= S_DONE;
          end else if (nonce == end_nonce) begin
            result_code <= RC_EXHAUSTED;
            state       <= S_DONE;
          end else if (abort) begin
            result_code <= RC_ABORTED;
            state       <= S_DONE;
          end else begin
            // Natural 32-bit wrap lets a range with end < start run through zero.
            nonce <= nonce + NONCE_W'(1);
            state <= S_LAUNCH;
          end
        end

        S_DONE: begin
          if (result_ack) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed and randomized bench for nonce_dispatcher with a 4-cycle hash core
// model and an expected-nonce queue checked on every launch.
module tb_nonce_dispatcher;
  import miner_pkg::*;

  localparam int TO = 16;
  localparam logic [607:0] HDR = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d};
  localparam logic [255:0] TGT = {32'h0, 32'hffff0000, 192'h0};

  logic         clk = 1'b0;
  logic         rst;
  logic         work_valid;
  logic         work_ready;
  logic [607:0] work_block;
  logic [255:0] work_target;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic         abort;
  logic         hash_enable;
  logic [607:0] block;
  logic [31:0]  nonce;
  logic [255:0] target;
  logic         finished;
  logic         correct;
  logic [255:0] hashed;
  logic         result_valid;
  logic         result_ack;
  logic [1:0]   result_code;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [32:0]  attempts;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int errors   = 0;
  int launches = 0;
  logic [31:0]  exp_q[$];
  logic [607:0] cur_blk;
  logic [255:0] cur_tgt;

  // core model
  int unsigned core_cnt = 0;
  logic [31:0] core_nonce = '0;
  logic        core_on = 1'b1;
  logic        win_en = 1'b0;
  logic [31:0] win_nonce = '0;

  nonce_dispatcher #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(work_ready),
    .work_block(work_block), .work_target(work_target),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .abort(abort),
    .hash_enable(hash_enable), .block(block), .nonce(nonce), .target(target),
    .finished(finished), .correct(correct), .hashed(hashed),
    .result_valid(result_valid), .result_ack(result_ack),
    .result_code(result_code), .found_nonce(found_nonce),
    .found_hash(found_hash), .attempts(attempts), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [255:0] model_hash(input logic [31:0] n);
    return {n, ~n, n ^ 32'h9e3779b9, {n[15:0], n[31:16]}, n + 32'h1, n, ~n, 32'hdeadbeef};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      core_cnt <= 0;
    end else if (hash_enable === 1'b1 && core_on) begin
      core_cnt   <= 4;
      core_nonce <= nonce;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end

  assign finished = (core_cnt == 1);
  assign correct  = finished && win_en && (core_nonce == win_nonce);
  assign hashed   = model_hash(core_nonce);

  task automatic chk(input string tag, input logic [607:0] obs, input logic [607:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every launch must present the next expected nonce and job data
  always @(negedge clk) begin
    if (rst === 1'b0 && hash_enable === 1'b1) begin
      logic [31:0] e;
      launches++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      chk("launch_nonce", nonce, e);
      chk("launch_block", block, cur_blk);
      chk("launch_target", target, cur_tgt);
    end
  end

  // driver tasks
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
    chk({tag, "_work_ready"}, work_ready, 1'b1);
    chk({tag, "_hash_enable"}, hash_enable, 1'b0);
    chk({tag, "_result_valid"}, result_valid, 1'b0);
    chk({tag, "_nonce"}, nonce, 32'h0);
    chk({tag, "_block"}, block, 608'h0);
    chk({tag, "_target"}, target, 256'h0);
    chk({tag, "_code"}, result_code, 2'b00);
    chk({tag, "_found_nonce"}, found_nonce, 32'h0);
    chk({tag, "_found_hash"}, found_hash, 256'h0);
    chk({tag, "_attempts"}, attempts, 33'h0);
  endtask

  task automatic send(input logic [31:0] st, input logic [31:0] en);
    @(negedge clk);
    chk("work_ready_before_accept", work_ready, 1'b1);
    work_valid  = 1'b1;
    work_block  = cur_blk;
    work_target = cur_tgt;
    nonce_start = st;
    nonce_end   = en;
    @(posedge clk);
    #1;
    work_valid  = 1'b0;
    work_block  = ~cur_blk;
    work_target = ~cur_tgt;
    nonce_start = $urandom();
    nonce_end   = $urandom();
  endtask

  task automatic wait_done(input int budget, input logic abort_hit);
    int n = 0;
    while (result_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      abort = abort_hit && (finished === 1'b1) && (correct === 1'b1);
      n++;
    end
    abort = 1'b0;
    chk("done_reached", result_valid, 1'b1);
  endtask

  task automatic finish_done(input logic [1:0] code, input logic [32:0] att);
    @(negedge clk);
    chk("done_hold_valid", result_valid, 1'b1);
    chk("done_hold_code", result_code, code);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_in_done_state", dbg_state, ST_DONE);
    chk("abort_in_done_attempts", attempts, att);
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    @(negedge clk);
    chk("ack_to_idle", dbg_state, ST_IDLE);
    chk("ack_work_ready", work_ready, 1'b1);
  endtask

  // reference: the job visits start, start+1, ... until the winner or the end
  task automatic run_job(input logic [31:0] st, input logic [31:0] en, input logic wen,
                         input logic [31:0] win, input logic abort_hit);
    logic [31:0] len;
    logic [31:0] off;
    logic        fnd;
    int          att;
    len = en - st;
    off = win - st;
    fnd = wen && (off <= len);
    att = fnd ? int'(off) + 1 : int'(len) + 1;
    for (int i = 0; i < att; i++) exp_q.push_back(st + 32'(i));
    core_on   = 1'b1;
    win_en    = wen;
    win_nonce = win;
    launches  = 0;
    send(st, en);
    wait_done(att * 12 + 40, abort_hit);
    chk("job_code", result_code, fnd ? RC_FOUND : RC_EXHAUSTED);
    chk("job_attempts", attempts, 33'(att));
    chk("job_found_nonce", found_nonce, fnd ? win : 32'h0);
    chk("job_found_hash", found_hash, fnd ? model_hash(win) : 256'h0);
    chk("job_last_nonce", nonce, fnd ? win : en);
    chk("job_launches", launches, att);
    chk("job_queue_drained", exp_q.size(), 0);
    finish_done(fnd ? RC_FOUND : RC_EXHAUSTED, 33'(att));
  endtask

  initial begin
    int          n;
    logic        rv_seen;
    logic [31:0] st;
    logic [31:0] len;
    rst = 1'b1; work_valid = 1'b0; work_block = '0; work_target = '0;
    nonce_start = '0; nonce_end = '0; abort = 1'b0; result_ack = 1'b0;
    cur_blk = HDR; cur_tgt = TGT;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("por");

    // found at the third nonce
    run_job(32'h9546a140, 32'h9546a14f, 1'b1, 32'h9546a142, 1'b0);
    // single-nonce range
    run_job(32'h00000005, 32'h00000005, 1'b0, 32'h0, 1'b0);
    // range through the 32-bit wrap
    run_job(32'hfffffffe, 32'h00000001, 1'b0, 32'h0, 1'b0);
    // finished and abort together: finished wins
    run_job(32'h9546a140, 32'h9546a14f, 1'b1, 32'h9546a142, 1'b1);

    // timeout: core never answers
    core_on = 1'b0;
    exp_q.push_back(32'h00000100);
    launches = 0;
    send(32'h00000100, 32'h000001ff);
    n = 0;
    while (dbg_state !== ST_WAIT && n < 10) begin @(negedge clk); n++; end
    chk("timeout_wait_entry", dbg_state, ST_WAIT);
    n = 0;
    while (dbg_state !== ST_DONE && n < 100) begin @(negedge clk); n++; end
    chk("timeout_latency", n, 16);
    chk("timeout_code", result_code, RC_TIMEOUT);
    chk("timeout_attempts", attempts, 33'h0);
    chk("timeout_found_nonce", found_nonce, 32'h0);
    chk("timeout_launches", launches, 1);
    finish_done(RC_TIMEOUT, 33'h0);

    // abort in LAUNCH is ignored, abort in WAIT ends the job
    core_on = 1'b1; win_en = 1'b0;
    exp_q.push_back(32'h00000010);
    launches = 0;
    send(32'h00000010, 32'h00000020);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_launch_pulse", hash_enable, 1'b1);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_launch_ignored", dbg_state, ST_WAIT);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_wait_state", dbg_state, ST_DONE);
    chk("abort_wait_code", result_code, RC_ABORTED);
    chk("abort_wait_attempts", attempts, 33'h0);
    chk("abort_wait_found_hash", found_hash, 256'h0);
    chk("abort_wait_launches", launches, 1);
    finish_done(RC_ABORTED, 33'h0);
    repeat (6) @(negedge clk);

    // reset during WAIT of the second attempt
    cur_blk = HDR ^ {19{32'h5a5a5a5a}};
    win_en = 1'b1; win_nonce = 32'h9546a142;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h9546a140 + 32'(i));
    launches = 0;
    send(32'h9546a140, 32'h9546a14f);
    n = 0;
    while (!(launches == 2 && dbg_state === ST_WAIT) && n < 60) begin @(negedge clk); n++; end
    chk("rst_reached_wait2", launches, 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_reset("midjob_rst");
    rv_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (result_valid !== 1'b0) rv_seen = 1'b1;
    end
    chk("rst_no_result", rv_seen, 1'b0);

    // randomized jobs
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 0) st = 32'hffffffff - 32'($urandom_range(0, 3));
      else st = $urandom();
      len = 32'($urandom_range(0, 6));
      cur_blk = {19{$urandom()}} ^ HDR;
      cur_tgt = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
      run_job(st, st + len, 1'($urandom_range(0, 1)),
              st + 32'($urandom_range(0, 8)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
